// File: rtl/cmt_xcript_seq.sv
// Prover-side CMT transcript sequencer: issues one header per proof message, then routes its words.
// Define CMT_SEQ_MUXSEL_EN to prepend a MUXSEL rx message whose word is latched into muxsel.
`timescale 1ns/1ps
module cmt_xcript_seq #(
  parameter int FW      = 61,
  parameter int NLAYERS = 3,
  parameter int NROUNDS = 8,
  parameter int NIN     = 16,
  parameter int NOUT    = 8,
  parameter int NQ0     = 3,
  parameter int NH      = 5,
  parameter int NQI     = 4,
  parameter int NMUX    = 4
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            start,
  input  logic            abort,
  output logic            hdr_valid,
  input  logic            hdr_ready,
  output logic [2:0]      hdr_type,
  output logic [7:0]      hdr_layer,
  output logic [7:0]      hdr_round,
  output logic [15:0]     hdr_len,
  input  logic [FW-1:0]   pv_data,
  input  logic            pv_valid,
  output logic            pv_ready,
  output logic [FW-1:0]   tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  input  logic [FW-1:0]   rx_data,
  input  logic            rx_valid,
  output logic            rx_ready,
  output logic [FW-1:0]   vd_data,
  output logic            vd_valid,
  input  logic            vd_ready,
  output logic [NMUX-1:0] muxsel,
  output logic            busy,
  output logic            done
);

  // Message type codes, mirroring the CMT_* values of verifier_interface_defs.v
  localparam logic [2:0] CMT_INPUT  = 3'd0;
  localparam logic [2:0] CMT_OUTPUT = 3'd1;
  localparam logic [2:0] CMT_Q0     = 3'd2;
  localparam logic [2:0] CMT_F012   = 3'd3;
  localparam logic [2:0] CMT_R      = 3'd4;
  localparam logic [2:0] CMT_H      = 3'd5;
  localparam logic [2:0] CMT_QI     = 3'd6;
  localparam logic [2:0] CMT_MUXSEL = 3'd7;

  localparam logic [7:0] LAST_ROUND = 8'(NROUNDS - 1);
  localparam logic [7:0] LAST_LAYER = 8'(NLAYERS - 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] wcnt;
  logic [2:0]  nxt_type;
  logic [7:0]  nxt_layer, nxt_round;
  logic        final_msg, is_tx, is_mux, active, xfer, last_word, load_hdr, hdr_acc;

  function automatic logic [15:0] msg_len(input logic [2:0] t);
    case (t)
      CMT_INPUT:  msg_len = 16'(NIN);
      CMT_OUTPUT: msg_len = 16'(NOUT);
      CMT_Q0:     msg_len = 16'(NQ0);
      CMT_F012:   msg_len = 16'd3;
      CMT_H:      msg_len = 16'(NH);
      CMT_QI:     msg_len = 16'(NQI);
      default:    msg_len = 16'd1;
    endcase
  endfunction

  // The current header registers double as the transcript position; derive the following message.
  always_comb begin
    nxt_type  = CMT_INPUT;
    nxt_layer = hdr_layer;
    nxt_round = 8'd0;
    final_msg = 1'b0;
    if (state_q == IDLE) begin
      nxt_layer = 8'd0;
`ifdef CMT_SEQ_MUXSEL_EN
      nxt_type = CMT_MUXSEL;
`endif
    end else begin
      case (hdr_type)
        CMT_MUXSEL: nxt_type = CMT_INPUT;
        CMT_INPUT:  nxt_type = CMT_OUTPUT;
        CMT_OUTPUT: nxt_type = CMT_Q0;
        CMT_Q0: begin
          nxt_type  = CMT_F012;
          nxt_layer = 8'd0;
        end
        CMT_F012: begin
          nxt_type  = CMT_R;
          nxt_round = hdr_round;
        end
        CMT_R: begin
          if (hdr_round == LAST_ROUND) begin
            nxt_type = CMT_H;
          end else begin
            nxt_type  = CMT_F012;
            nxt_round = hdr_round + 8'd1;
          end
        end
        CMT_H: begin
          if (hdr_layer == LAST_LAYER) begin
            nxt_type  = CMT_H;
            final_msg = 1'b1;
          end else begin
            nxt_type  = CMT_QI;
            nxt_layer = hdr_layer + 8'd1;
          end
        end
        CMT_QI: nxt_type = CMT_F012;
      endcase
    end
  end

  always_comb begin
    active    = (state_q == DATA) && !abort;
    is_tx     = (hdr_type == CMT_OUTPUT) || (hdr_type == CMT_F012) || (hdr_type == CMT_H);
    is_mux    = (hdr_type == CMT_MUXSEL);
    tx_valid  = 1'b0;
    pv_ready  = 1'b0;
    tx_data   = '0;
    vd_valid  = 1'b0;
    rx_ready  = 1'b0;
    vd_data   = '0;
    xfer      = 1'b0;
    if (active) begin
      if (is_tx) begin
        tx_valid = pv_valid;
        pv_ready = tx_ready;
        tx_data  = pv_data;
        xfer     = pv_valid && tx_ready;
      end else if (is_mux) begin
        rx_ready = 1'b1;
        xfer     = rx_valid;
      end else begin
        vd_valid = rx_valid;
        rx_ready = vd_ready;
        vd_data  = rx_data;
        xfer     = rx_valid && vd_ready;
      end
    end
    last_word = (wcnt == hdr_len - 16'd1);
  end

  always_comb begin
    state_d   = state_q;
    hdr_valid = 1'b0;
    busy      = (state_q == HDR) || (state_q == DATA);
    done      = (state_q == DONE);
    case (state_q)
      IDLE: if (start) state_d = HDR;
      HDR: begin
        hdr_valid = !abort;
        if (hdr_ready) state_d = DATA;
      end
      DATA: if (xfer && last_word) state_d = final_msg ? DONE : HDR;
      DONE: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
    hdr_acc  = hdr_valid && hdr_ready;
    load_hdr = ((state_q == IDLE) && start) || (xfer && last_word && !final_msg);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Header fields only change when entering HDR, so they stay put while a header is stalled.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wcnt      <= '0;
      hdr_type  <= '0;
      hdr_layer <= '0;
      hdr_round <= '0;
      hdr_len   <= '0;
    end else if (abort || state_q == DONE) begin
      wcnt      <= '0;
      hdr_type  <= '0;
      hdr_layer <= '0;
      hdr_round <= '0;
      hdr_len   <= '0;
    end else begin
      if (load_hdr) begin
        hdr_type  <= nxt_type;
        hdr_layer <= nxt_layer;
        hdr_round <= nxt_round;
        hdr_len   <= msg_len(nxt_type);
      end
      if (hdr_acc)   wcnt <= '0;
      else if (xfer) wcnt <= last_word ? 16'd0 : wcnt + 16'd1;
    end
  end

`ifdef CMT_SEQ_MUXSEL_EN
  logic [NMUX-1:0] muxsel_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)               muxsel_q <= '0;
    else if (xfer && is_mux) muxsel_q <= rx_data[NMUX-1:0];
  end

  assign muxsel = muxsel_q;
`else
  assign muxsel = '0;
`endif

endmodule

// File: tb/tb_cmt_xcript_seq.sv
// Bench for cmt_xcript_seq: header scoreboard from a transcript model, word queues for both directions.
// Exercises default depth and a 1-layer/1-round instance, backpressure, abort and mid-proof reset.
`timescale 1ns/1ps
module tb_cmt_xcript_seq;
  localparam int FW = 61, NIN = 16, NOUT = 8, NQ0 = 3, NH = 5, NQI = 4, NMUX = 4;
  localparam logic [2:0] T_INPUT = 3'd0, T_OUTPUT = 3'd1, T_Q0 = 3'd2, T_F012 = 3'd3,
                         T_R = 3'd4, T_H = 3'd5, T_QI = 3'd6, T_MUXSEL = 3'd7;
`ifdef CMT_SEQ_MUXSEL_EN
  localparam int MX = 1;
`else
  localparam int MX = 0;
`endif

  typedef struct packed {
    logic [2:0]  t;
    logic [7:0]  l;
    logic [7:0]  r;
    logic [15:0] n;
  } hdr_t;

  logic clk = 1'b0;
  logic rstb = 1'b0, abort = 1'b0, hdr_ready = 1'b0, pv_valid = 1'b0, tx_ready = 1'b0;
  logic rx_valid = 1'b0, vd_ready = 1'b0, start_main = 1'b0, start_noise = 1'b0;
  logic start0, start1;
  logic [FW-1:0] pv_data = '0, rx_data = '0;
  int sel = 0;

  logic            hv[2], pr[2], tv[2], rr[2], vv[2], bz[2], dn[2];
  logic [2:0]      ht[2];
  logic [7:0]      hl[2], hr[2];
  logic [15:0]     hn[2];
  logic [FW-1:0]   td[2], vdd[2];
  logic [NMUX-1:0] ms[2];

  assign start0 = (sel == 0) && (start_main || start_noise);
  assign start1 = (sel == 1) && (start_main || start_noise);

  always #5 clk = ~clk;

  cmt_xcript_seq #(.FW(FW), .NLAYERS(3), .NROUNDS(8), .NIN(NIN), .NOUT(NOUT), .NQ0(NQ0),
                   .NH(NH), .NQI(NQI), .NMUX(NMUX)) dut0 (
    .clk(clk), .rstb(rstb), .start(start0), .abort(abort),
    .hdr_valid(hv[0]), .hdr_ready(hdr_ready), .hdr_type(ht[0]), .hdr_layer(hl[0]),
    .hdr_round(hr[0]), .hdr_len(hn[0]),
    .pv_data(pv_data), .pv_valid(pv_valid), .pv_ready(pr[0]),
    .tx_data(td[0]), .tx_valid(tv[0]), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rr[0]),
    .vd_data(vdd[0]), .vd_valid(vv[0]), .vd_ready(vd_ready),
    .muxsel(ms[0]), .busy(bz[0]), .done(dn[0]));

  cmt_xcript_seq #(.FW(FW), .NLAYERS(1), .NROUNDS(1), .NIN(NIN), .NOUT(NOUT), .NQ0(NQ0),
                   .NH(NH), .NQI(NQI), .NMUX(NMUX)) dut1 (
    .clk(clk), .rstb(rstb), .start(start1), .abort(abort),
    .hdr_valid(hv[1]), .hdr_ready(hdr_ready), .hdr_type(ht[1]), .hdr_layer(hl[1]),
    .hdr_round(hr[1]), .hdr_len(hn[1]),
    .pv_data(pv_data), .pv_valid(pv_valid), .pv_ready(pr[1]),
    .tx_data(td[1]), .tx_valid(tv[1]), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rr[1]),
    .vd_data(vdd[1]), .vd_valid(vv[1]), .vd_ready(vd_ready),
    .muxsel(ms[1]), .busy(bz[1]), .done(dn[1]));

  hdr_t          expq[$];
  hdr_t          cur, held;
  logic [FW-1:0] txq[$], vdq[$];
  logic [FW-1:0] pv_next = 'h1000, rx_next = 'h5000;
  bit            mon_en = 0, rnd_mode = 0, in_msg = 0, held_valid = 0;
  int            wcount, hdr_count, words, done_count, exp_nhdr, exp_words;
  int            n_checks = 0, n_fail = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit isTx(input logic [2:0] t);
    return (t == T_OUTPUT) || (t == T_F012) || (t == T_H);
  endfunction

  function automatic bit isRx(input logic [2:0] t);
    return (t == T_INPUT) || (t == T_Q0) || (t == T_R) || (t == T_QI);
  endfunction

  task automatic pushHdr(input logic [2:0] t, input int l, input int r, input int n);
    expq.push_back('{t: t, l: 8'(l), r: 8'(r), n: 16'(n)});
    exp_words += n;
  endtask

  task automatic buildHeaders(input int nl, input int nr);
    expq.delete();
    exp_words = 0;
    if (MX == 1) pushHdr(T_MUXSEL, 0, 0, 1);
    pushHdr(T_INPUT, 0, 0, NIN);
    pushHdr(T_OUTPUT, 0, 0, NOUT);
    pushHdr(T_Q0, 0, 0, NQ0);
    for (int l = 0; l < nl; l++) begin
      for (int r = 0; r < nr; r++) begin
        pushHdr(T_F012, l, r, 3);
        pushHdr(T_R, l, r, 1);
      end
      pushHdr(T_H, l, 0, NH);
      if (l < nl - 1) pushHdr(T_QI, l + 1, 0, NQI);
    end
    exp_nhdr = expq.size();
  endtask

  // Input driver: fresh handshake pattern each cycle, word values advance only when accepted.
  always @(posedge clk) begin
    #1;
    if (rnd_mode) begin
      hdr_ready   = 1'($urandom_range(0, 1));
      tx_ready    = 1'($urandom_range(0, 1));
      vd_ready    = 1'($urandom_range(0, 1));
      pv_valid    = 1'($urandom_range(0, 1));
      rx_valid    = 1'($urandom_range(0, 1));
      start_noise = bz[sel] && ($urandom_range(0, 7) == 0);
    end else begin
      hdr_ready = 1'b1; tx_ready = 1'b1; vd_ready = 1'b1;
      pv_valid  = 1'b1; rx_valid = 1'b1; start_noise = 1'b0;
    end
    pv_data = pv_next;
    rx_data = (in_msg && cur.t == T_MUXSEL) ? FW'(4'hA) : rx_next;
  end

  // Monitor: headers against the model queue, words against what the driver handed over.
  always @(negedge clk) begin
    hdr_t obs;
    hdr_t eh;
    if (mon_en && rstb) begin
      obs = '{t: ht[sel], l: hl[sel], r: hr[sel], n: hn[sel]};
      if (hv[sel]) begin
        if (held_valid) checkOutput("hdr_stable", obs, held);
        if (hdr_ready) begin
          if (in_msg) checkOutput("msg_words", wcount, cur.n);
          checkOutput("hdr_expected", expq.size() > 0, 1);
          eh = obs;
          if (expq.size() > 0) begin
            eh = expq.pop_front();
            checkOutput("hdr_type", obs.t, eh.t);
            checkOutput("hdr_layer", obs.l, eh.l);
            checkOutput("hdr_round", obs.r, eh.r);
            checkOutput("hdr_len", obs.n, eh.n);
          end
          cur = eh;
          in_msg = 1;
          wcount = 0;
          hdr_count++;
          held_valid = 0;
        end else begin
          held = obs;
          held_valid = 1;
        end
      end else begin
        held_valid = 0;
      end

      if (pv_valid && pr[sel]) begin
        txq.push_back(pv_data);
        pv_next++;
      end
      if (tv[sel] && tx_ready) begin
        checkOutput("tx_dir", in_msg && isTx(cur.t), 1);
        checkOutput("tx_q_nonempty", txq.size() > 0, 1);
        if (txq.size() > 0) checkOutput("tx_data", td[sel], txq.pop_front());
        wcount++;
        words++;
      end
      if (rx_valid && rr[sel]) begin
        if (in_msg && cur.t == T_MUXSEL) begin
          wcount++;
          words++;
        end else begin
          vdq.push_back(rx_data);
          rx_next++;
        end
      end
      if (vv[sel] && vd_ready) begin
        checkOutput("rx_dir", in_msg && isRx(cur.t), 1);
        checkOutput("vd_q_nonempty", vdq.size() > 0, 1);
        if (vdq.size() > 0) checkOutput("vd_data", vdd[sel], vdq.pop_front());
        wcount++;
        words++;
      end

      if (dn[sel]) begin
        done_count++;
        checkOutput("busy_at_done", bz[sel], 0);
        checkOutput("last_msg_words", in_msg ? wcount : -1, cur.n);
        checkOutput("hdr_q_drained", expq.size(), 0);
        in_msg = 0;
      end
    end
  end

  task automatic applyStimulus(input int which, input bit rnd);
    sel = which;
    rnd_mode = rnd;
    buildHeaders(which == 0 ? 3 : 1, which == 0 ? 8 : 1);
    txq.delete();
    vdq.delete();
    in_msg = 0; held_valid = 0; wcount = 0; hdr_count = 0; words = 0; done_count = 0;
    mon_en = 1;
    @(posedge clk); #1 start_main = 1'b1;
    @(posedge clk); #1 start_main = 1'b0;
    checkOutput("hdr_rise", hv[sel], 1);
  endtask

  task automatic waitDone(input int which, input int budget);
    int k = 0;
    while (done_count == 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    checkOutput("done_timeout", k < budget, 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_once", done_count, 1);
    checkOutput("busy_after", bz[which], 0);
    checkOutput("hdr_valid_after", hv[which], 0);
    checkOutput("hdr_total", hdr_count, exp_nhdr);
    checkOutput("hdr_total_fixed", hdr_count, (which == 0) ? 56 + MX : 6 + MX);
    checkOutput("word_total", words, exp_words);
    checkOutput("word_total_fixed", words, (which == 0) ? 146 + MX : 36 + MX);
    checkOutput("tx_q_drained", txq.size(), 0);
    checkOutput("vd_q_drained", vdq.size(), 0);
    checkOutput("muxsel", ms[which], (MX == 1) ? 4'hA : 4'h0);
  endtask

  initial begin
    #12;
    checkOutput("rst_hdr_valid", hv[0], 0);
    checkOutput("rst_busy", bz[0], 0);
    checkOutput("rst_done", dn[0], 0);
    checkOutput("rst_hdr_len", hn[0], 0);
    checkOutput("rst_tx_valid", tv[0], 0);
    checkOutput("rst_vd_valid", vv[0], 0);
    checkOutput("rst_muxsel", ms[0], 0);
    @(posedge clk); #2 rstb = 1'b1;

    $display("[TB] full proof, no backpressure");
    applyStimulus(0, 0);
    waitDone(0, 2000);

    $display("[TB] full proof, random backpressure");
    applyStimulus(0, 1);
    waitDone(0, 6000);

    $display("[TB] single layer, single round");
    applyStimulus(1, 0);
    waitDone(1, 1000);

    $display("[TB] abort in layer 1 round 3 F012");
    applyStimulus(0, 1);
    begin
      int k = 0;
      while (!(in_msg && cur.t == T_F012 && cur.l == 8'd1 && cur.r == 8'd3 &&
               wcount >= 1 && wcount < 3) && k < 4000) begin
        @(posedge clk); #2;
        k++;
      end
      checkOutput("abort_point_reached", k < 4000, 1);
    end
    mon_en = 0;
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    checkOutput("abort_busy", bz[0], 0);
    checkOutput("abort_hdr_valid", hv[0], 0);
    checkOutput("abort_tx_valid", tv[0], 0);
    checkOutput("abort_vd_valid", vv[0], 0);
    applyStimulus(0, 0);
    waitDone(0, 2000);

    $display("[TB] reset in the middle of Q0");
    applyStimulus(0, 1);
    begin
      int k = 0;
      while (!(in_msg && cur.t == T_Q0 && wcount >= 1 && wcount < 3) && k < 4000) begin
        @(posedge clk); #2;
        k++;
      end
      checkOutput("q0_point_reached", k < 4000, 1);
    end
    mon_en = 0;
    rstb = 1'b0;
    #1;
    checkOutput("arst_hdr_valid", hv[0], 0);
    checkOutput("arst_busy", bz[0], 0);
    checkOutput("arst_tx_valid", tv[0], 0);
    checkOutput("arst_vd_valid", vv[0], 0);
    checkOutput("arst_pv_ready", pr[0], 0);
    checkOutput("arst_rx_ready", rr[0], 0);
    checkOutput("arst_hdr_type", ht[0], 0);
    checkOutput("arst_hdr_len", hn[0], 0);
    @(posedge clk); #1 rstb = 1'b1;
    applyStimulus(0, 1);
    waitDone(0, 6000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cmt_xcript_seq.md
# cmt_xcript_seq

Synthesizable transcript sequencer for the prover side of the CMT verifier interface. It walks the full proof message order for a circuit with parameterised depth, round count and message lengths. For each message it issues a header on a valid/ready channel, then moves that message's field words in the correct direction: prover datapath to transport for sends, transport to datapath for requests. It replaces hand-scripted send/request sequences and sits between the prover datapath and the verifier transport.

## Interface
- FW, 61: field element width
- NLAYERS, 3: circuit depth (sumcheck layers), ≥1
- NROUNDS, 8: sumcheck rounds per layer, ≥1
- NIN, 16: INPUT words
- NOUT, 8: OUTPUT words
- NQ0, 3: Q0 words
- NH, 5: H words per layer
- NQI, 4: QI words per layer transition
- NMUX, 4: mux-select bits (used only with CMT_SEQ_MUXSEL_EN)
- clk  in  1  clock
- rstb  in  1  reset, asynchronous, active-low
- start  in  1  begin a proof; sampled only in IDLE
- abort  in  1  synchronous; return to IDLE next cycle
- hdr_valid  out  1  header offered
- hdr_ready  in  1  header accepted
- hdr_type  out  3  message type, encoded with the CMT_* values from verifier_interface_defs.v
- hdr_layer  out  8  layer index
- hdr_round  out  8  round index; 0 for non-sumcheck messages
- hdr_len  out  16  word count of this message
- pv_data/pv_valid/pv_ready  in/in/out  FW/1/1  prover words for send messages
- tx_data/tx_valid/tx_ready  out/out/in  FW/1/1  to transport
- rx_data/rx_valid/rx_ready  in/in/out  FW/1/1  from transport
- vd_data/vd_valid/vd_ready  out/out/in  FW/1/1  to prover datapath
- muxsel  out  NMUX  captured mux-select bits
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse at proof end

## Operation
- Message order:
  - [MUXSEL rx, 1 word]
  - INPUT rx NIN
  - OUTPUT tx NOUT
  - Q0 rx NQ0
  - then for each layer l = 0..NLAYERS-1:
    - for each round r = 0..NROUNDS-1: F012 tx 3 words, then R rx 1 word
    - H tx NH
    - if l < NLAYERS-1: QI rx NQI, with hdr_layer = l+1
- FSM states:
  - IDLE: start → HDR
  - HDR: hdr_valid=1; on hdr_valid&hdr_ready → DATA
  - DATA: on the last word transfer, → HDR for the next message, or → DONE after the final H
  - DONE: done=1 for one cycle → IDLE
- Data paths are combinational pass-through, active only in DATA:
  - tx direction: tx_valid=pv_valid, pv_ready=tx_ready, tx_data=pv_data
  - rx direction: vd_valid=rx_valid, rx_ready=vd_ready, vd_data=rx_data
  - all other valid/ready outputs are 0
- A word transfers when valid&ready. The word counter resets on every header acceptance.
- Header fields are registered and stable while hdr_valid=1.
- start while busy is ignored. abort takes priority over all transfers and clears counters; the aborted message is not completed.
- Reset values: all outputs 0, FSM in IDLE, muxsel 0.

## Timing
- hdr_valid rises the cycle after start is sampled in IDLE.
- First data transfer can occur the cycle after header acceptance.
- After the last word of a message, the next header is valid the following cycle. Each message costs at least 1 header cycle + len data cycles.
- done pulses the cycle after the last H word of layer NLAYERS-1. busy falls the same cycle done is high → IDLE next cycle.
- rstb asserted mid-proof: immediate return to reset values; the transaction is dropped.

## Configuration
- CMT_SEQ_MUXSEL_EN defined:
  - a MUXSEL rx header (layer 0, round 0, len 1) precedes INPUT
  - its word's low NMUX bits are latched into muxsel; the word is not forwarded on vd_*
  - muxsel holds until the next reset
- Undefined: no MUXSEL message; muxsel is tied to 0.

## Test plan
- Defaults, macro off, all ready/valid held high, start pulse → 56 headers in exact order, 146 data words, done pulse once, busy low after.
- Random backpressure on hdr_ready, tx_ready, vd_ready and random pv_valid/rx_valid → identical header sequence and word counts, no word lost or duplicated, header fields stable while stalled.
- NLAYERS=1, NROUNDS=1 → headers INPUT, OUTPUT, Q0, F012(0,0), R(0,0), H(0); no QI; done.
- abort asserted during layer-1 round-3 F012 data → IDLE next cycle, all valids 0; new start replays from INPUT.
- rstb low mid-Q0 → all outputs 0 asynchronously; after release, start runs a full clean proof.
- Macro on, rx MUXSEL word 0xA → muxsel=4'hA, not seen on vd_*, then normal INPUT header.
